// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered sequential ALU with iterative one-bit-per-clock shifts
//
// Purpose:
//   Parametrised datapath ALU. Operands are captured when start is seen while
//   the unit is idle. Single-cycle ops update result/flags at the accept edge.
//   SHL/SHR with a nonzero amount k shift one bit per clock and complete k edges
//   after the accept edge. done pulses for one cycle after every completion.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   operation request, ignored while busy
//   op      in   3-bit opcode (RST, LD, ADD, SUB, NOR, SHL, SHR, ADC)
//   a       in   operand A
//   b       in   operand B, or shift amount in b[SHW-1:0]
//   result  out  registered result
//   cout    out  registered carry/borrow/shift-out flag (stored carry)
//   zout    out  registered zero flag
//   vout    out  registered signed-overflow flag
//   busy    out  high while a shift is in progress
//   done    out  one-cycle completion pulse

module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zout,
    output logic             vout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_RST = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_ADC = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zout_q, zout_d;
    logic             vout_q, vout_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;

    // Arithmetic at WIDTH+1 bits so the top bit is the carry/borrow.
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [WIDTH:0]   sum_adc;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] step_val;
    logic             step_out;

    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} - {1'b0, b};
    assign sum_adc = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cout_q};
    assign shamt   = b[SHW-1:0];

    // One-bit shift of the work register; step_out is the bit that falls off.
    always_comb begin
        step_val = '0;
        step_out = 1'b0;
        if (left_q) begin
            step_val = {work_q[WIDTH-2:0], 1'b0};
            step_out = work_q[WIDTH-1];
        end else begin
            step_val = {1'b0, work_q[WIDTH-1:1]};
            step_out = work_q[0];
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cout_d   = cout_q;
        zout_d   = zout_q;
        vout_d   = vout_q;
        done_d   = 1'b0;
        work_d   = work_q;
        cnt_d    = cnt_q;
        left_d   = left_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((op == OP_SHL || op == OP_SHR) && shamt != '0) begin
                        work_d  = a;
                        cnt_d   = shamt;
                        left_d  = (op == OP_SHL);
                        state_d = S_SHIFT;
                    end else begin
                        vout_d = 1'b0;
                        cout_d = 1'b0;
                        case (op)
                            OP_RST: result_d = '0;
                            OP_LD:  result_d = a;
                            OP_ADD: begin
                                result_d = sum_add[WIDTH-1:0];
                                cout_d   = sum_add[WIDTH];
                                vout_d   = (a[WIDTH-1] == b[WIDTH-1]) &&
                                           (sum_add[WIDTH-1] != a[WIDTH-1]);
                            end
                            OP_SUB: begin
                                result_d = sum_sub[WIDTH-1:0];
                                cout_d   = sum_sub[WIDTH];
                                vout_d   = (a[WIDTH-1] != b[WIDTH-1]) &&
                                           (sum_sub[WIDTH-1] != a[WIDTH-1]);
                            end
                            OP_NOR: result_d = ~(a | b);
                            OP_ADC: begin
                                result_d = sum_adc[WIDTH-1:0];
                                cout_d   = sum_adc[WIDTH];
                                vout_d   = (a[WIDTH-1] == b[WIDTH-1]) &&
                                           (sum_adc[WIDTH-1] != a[WIDTH-1]);
                            end
                            // Zero-amount shifts pass A straight through.
                            default: result_d = a;
                        endcase
                        zout_d = (result_d == '0);
                        done_d = 1'b1;
                    end
                end
            end

            S_SHIFT: begin
                work_d = step_val;
                cnt_d  = cnt_q - 1'b1;
                // Last step: publish the freshly shifted value directly.
                if (cnt_q == SHW'(1)) begin
                    result_d = step_val;
                    cout_d   = step_out;
                    zout_d   = (step_val == '0);
                    vout_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            cout_q   <= 1'b0;
            zout_q   <= 1'b1;
            vout_q   <= 1'b0;
            done_q   <= 1'b0;
            work_q   <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zout_q   <= zout_d;
            vout_q   <= vout_d;
            done_q   <= done_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign zout   = zout_q;
    assign vout   = vout_q;
    assign done   = done_q;
    assign busy   = (state_q == S_SHIFT);

endmodule
